uart_tx_fifo: RTL and testbench

//  Buffered, parametrised UART transmitter. Accepts words on the tx_load/tx_data/tx_ready handshake into
//  an internal FIFO and serialises them on tx with configurable data bits, parity and stop bits.
//  It sits between the CPU I/O logic and the serial pin and supports back-to-back output.

---
 rtl/uart_tx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a small FIFO feeding a start/data/parity/stop serialiser.
// The serial line is registered and frames run back-to-back while words remain queued.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_load,
  input  logic [DATA_BITS-1:0]        tx_data,
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int BAW = $clog2(CLKS_PER_BIT);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0]  FIFO_FULL = CW'(FIFO_DEPTH);
  localparam logic [BAW-1:0] BAUD_LAST = BAW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic           STOP_LAST = (STOP_BITS == 2);
  localparam logic           PAR_ODD   = (PARITY == 1);
  localparam logic           HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_next;
  logic [BAW-1:0]       baud_cnt, baud_next;
  logic [BW-1:0]        bit_cnt, bit_next;
  logic                 stop_cnt, stop_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 tx_next;
  logic                 pop;
  logic                 wr_en;
  logic                 bit_end;
  logic                 fifo_empty;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] fifo_head;

  assign tx_ready   = (fifo_count != FIFO_FULL);
  assign fifo_empty = (fifo_count == '0);
  assign wr_en      = tx_load && tx_ready;
  assign fifo_head  = mem[rd_ptr];
  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign busy       = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // tx_ready comes from the registered count, so a load while full is dropped even if a pop coincides
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= tx_load && !tx_ready;
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shift_reg <= '0;
      tx        <= 1'b1;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_cnt   <= bit_next;
      stop_cnt  <= stop_next;
      shift_reg <= shift_next;
      tx        <= tx_next;
    end
  end

  // tx is registered from the next state, so the start bit appears on the same edge as the pop
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt + BAW'(1);
    bit_next   = bit_cnt;
    stop_next  = stop_cnt;
    shift_next = shift_reg;
    pop        = 1'b0;
    tx_next    = 1'b1;

    case (state)
      S_IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_head;
          state_next = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_cnt == BIT_LAST) begin
            stop_next  = 1'b0;
            state_next = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_next = bit_cnt + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          baud_next  = '0;
          stop_next  = 1'b0;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_next = '0;
          if (stop_cnt == STOP_LAST) begin
            if (!fifo_empty) begin
              pop        = 1'b1;
              shift_next = fifo_head;
              state_next = S_START;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            stop_next = stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        baud_next  = '0;
        state_next = S_IDLE;
      end
    endcase

    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[bit_next];
      S_PARITY: tx_next = (^shift_next) ^ PAR_ODD;
      default:  tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three differently configured instances share one clock and a
// frame-level reference model predicts every serial bit and every status output cycle by cycle.
module tb_uart_tx_fifo;

  localparam int NL = 3;
  localparam int QS = 256;

  int cpb_c [NL] = '{16, 4, 4};
  int db_c  [NL] = '{8, 7, 7};
  int par_c [NL] = '{0, 2, 1};
  int sb_c  [NL] = '{1, 1, 2};
  int dep_c [NL] = '{4, 4, 2};

  logic          clk = 1'b0;
  logic [NL-1:0] rst_v;
  logic [NL-1:0] load_v;
  logic [8:0]    data_v [NL];
  wire  [NL-1:0] ready_v, tx_v, busy_v, ovf_v;
  wire  [2:0]    cnt0, cnt1;
  wire  [1:0]    cnt2;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         q_start [NL][QS];
  logic [8:0] q_data  [NL][QS];
  int         q_head [NL];
  int         q_tail [NL];
  int         last_end [NL];
  int         frame_err [NL];
  int         exp_cnt [NL];
  logic       exp_ovf [NL];
  logic       exp_busy [NL];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(16), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst_v[0]), .tx_load(load_v[0]), .tx_data(data_v[0][7:0]), .tx_ready(ready_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .fifo_count(cnt0), .overflow(ovf_v[0]));

  uart_tx_fifo #(.DATA_BITS(7), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst_v[1]), .tx_load(load_v[1]), .tx_data(data_v[1][6:0]), .tx_ready(ready_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .fifo_count(cnt1), .overflow(ovf_v[1]));

  uart_tx_fifo #(.DATA_BITS(7), .CLKS_PER_BIT(4), .FIFO_DEPTH(2), .PARITY(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst_v[2]), .tx_load(load_v[2]), .tx_data(data_v[2][6:0]), .tx_ready(ready_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .fifo_count(cnt2), .overflow(ovf_v[2]));

  function automatic int frame_len(input int l);
    return (1 + db_c[l] + ((par_c[l] != 0) ? 1 : 0) + sb_c[l]) * cpb_c[l];
  endfunction

  // Bit b of the frame for word d: start, data LSB first, optional parity, then stop bits
  function automatic logic frame_bit(input int l, input logic [8:0] d, input int b);
    logic x;
    x = 1'b0;
    for (int i = 0; i < db_c[l]; i++) x = x ^ d[i];
    if (b == 0) return 1'b0;
    if (b <= db_c[l]) return d[b-1];
    if (par_c[l] != 0 && b == db_c[l] + 1) return (par_c[l] == 1) ? ~x : x;
    return 1'b1;
  endfunction

  function automatic int cnt_of(input int l);
    case (l)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int l, input logic [8:0] d);
    load_v[l] = 1'b1;
    data_v[l] = d;
    @(negedge clk);
    load_v[l] = 1'b0;
  endtask

  task automatic waitIdle(input int l, input int limit);
    for (int i = 0; i < limit && busy_v[l] !== 1'b0; i++) @(negedge clk);
  endtask

  // Reference model: a word accepted at edge n starts at max(n+1, end of previous frame)
  initial begin
    forever begin
      @(posedge clk);
      for (int l = 0; l < NL; l++) begin
        int n, occ, st, s;
        n = cyc + 1;
        occ = 0;
        for (int k = q_head[l]; k < q_tail[l]; k++)
          if (q_start[l][k % QS] >= n) occ++;
        exp_ovf[l] = 1'b0;
        if (rst_v[l]) begin
          q_head[l]    = q_tail[l];
          last_end[l]  = 0;
          frame_err[l] = 0;
        end else if (load_v[l]) begin
          if (occ < dep_c[l]) begin
            st = (n + 1 > last_end[l]) ? n + 1 : last_end[l];
            q_start[l][q_tail[l] % QS] = st;
            q_data[l][q_tail[l] % QS]  = data_v[l];
            q_tail[l]++;
            last_end[l] = st + frame_len(l);
          end else begin
            exp_ovf[l] = 1'b1;
          end
        end
        exp_cnt[l]  = 0;
        exp_busy[l] = 1'b0;
        for (int k = q_head[l]; k < q_tail[l]; k++) begin
          s = q_start[l][k % QS];
          if (s > n) exp_cnt[l]++;
          else if (n <= s + frame_len(l) - 1) exp_busy[l] = 1'b1;
        end
        if (exp_cnt[l] != 0) exp_busy[l] = 1'b1;
      end
      cyc = cyc + 1;
    end
  end

  // Monitor: status every cycle, tx against the head frame, one verdict per completed frame
  initial begin
    forever begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        int act, expv, s;
        logic [8:0] d;
        act  = (cnt_of(l) << 3) | (int'(ready_v[l]) << 2) | (int'(busy_v[l]) << 1) | int'(ovf_v[l]);
        expv = (exp_cnt[l] << 3) | ((exp_cnt[l] < dep_c[l]) ? 4 : 0) | (exp_busy[l] ? 2 : 0) |
               (exp_ovf[l] ? 1 : 0);
        checkOutput($sformatf("status lane%0d {count,ready,busy,ovf}", l), act, expv);
        if (q_head[l] != q_tail[l] && q_start[l][q_head[l] % QS] <= cyc) begin
          s = q_start[l][q_head[l] % QS];
          d = q_data[l][q_head[l] % QS];
          if (tx_v[l] !== frame_bit(l, d, (cyc - s) / cpb_c[l])) frame_err[l]++;
          if (cyc == s + frame_len(l) - 1) begin
            checkOutput($sformatf("frame lane%0d word %0h wrong-bit cycles", l, d), frame_err[l], 0);
            frame_err[l] = 0;
            q_head[l]++;
          end
        end else begin
          checkOutput($sformatf("tx idle lane%0d", l), int'(tx_v[l]), 1);
        end
      end
    end
  end

  initial begin
    int s;
    rst_v  = '1;
    load_v = '0;
    for (int l = 0; l < NL; l++) data_v[l] = '0;
    repeat (3) @(negedge clk);
    rst_v = '0;
    @(negedge clk);
    checkOutput("reset tx", int'(tx_v[0]), 1);
    checkOutput("reset ready", int'(ready_v[0]), 1);
    checkOutput("reset count", cnt_of(0), 0);

    // single 0x55 frame on the default lane
    applyStimulus(0, 9'h055);
    @(negedge clk);
    s = cyc;
    checkOutput("t1 start bit", int'(tx_v[0]), 0);
    for (int b = 0; b < 8; b++) begin
      repeat (16) @(negedge clk);
      checkOutput($sformatf("t1 data bit %0d", b), int'(tx_v[0]), (b % 2 == 0) ? 1 : 0);
    end
    repeat (16) @(negedge clk);
    checkOutput("t1 stop bit", int'(tx_v[0]), 1);
    waitIdle(0, 400);
    checkOutput("t1 frame length", cyc - s, 160);

    // even parity on 0x07 with 7 data bits
    applyStimulus(1, 9'h007);
    @(negedge clk);
    s = cyc;
    repeat (32) @(negedge clk);
    checkOutput("t3 even parity bit", int'(tx_v[1]), 1);
    waitIdle(1, 200);
    checkOutput("t3 even frame length", cyc - s, 40);

    // odd parity, two stop bits, two frames back-to-back
    applyStimulus(2, 9'h007);
    applyStimulus(2, 9'h05a);
    s = cyc;
    repeat (32) @(negedge clk);
    checkOutput("t3 odd parity bit", int'(tx_v[2]), 0);
    repeat (4) @(negedge clk);
    checkOutput("t6 stop first cycle", int'(tx_v[2]), 1);
    repeat (7) @(negedge clk);
    checkOutput("t6 stop last cycle", int'(tx_v[2]), 1);
    @(negedge clk);
    checkOutput("t6 next start bit", int'(tx_v[2]), 0);
    waitIdle(2, 300);
    checkOutput("t6 two frame length", cyc - s, 88);

    // fill the FIFO while idle, then overflow
    for (int i = 0; i < 5; i++) applyStimulus(0, 9'($urandom_range(0, 255)));
    checkOutput("t2 count full", cnt_of(0), 4);
    checkOutput("t2 ready low", int'(ready_v[0]), 0);
    applyStimulus(0, 9'h0ff);
    checkOutput("t2 overflow pulse", int'(ovf_v[0]), 1);
    checkOutput("t2 count held", cnt_of(0), 4);
    @(negedge clk);
    checkOutput("t2 overflow clears", int'(ovf_v[0]), 0);
    s = cyc - 5;
    repeat (154) @(negedge clk);
    checkOutput("t4 last stop cycle", int'(tx_v[0]), 1);
    @(negedge clk);
    checkOutput("t4 back-to-back start", int'(tx_v[0]), 0);
    waitIdle(0, 2000);
    checkOutput("t2 all frames done", int'(busy_v[0]), 0);

    // reset in the middle of data bit 3 with words still queued
    applyStimulus(0, 9'h0a5);
    applyStimulus(0, 9'h03c);
    applyStimulus(0, 9'h0c3);
    repeat (67) @(negedge clk);
    checkOutput("t5 inside data bit 3", int'(tx_v[0]), 0);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    checkOutput("t5 tx after reset", int'(tx_v[0]), 1);
    checkOutput("t5 count after reset", cnt_of(0), 0);
    checkOutput("t5 busy after reset", int'(busy_v[0]), 0);
    repeat (300) @(negedge clk);
    checkOutput("t5 nothing resumed", int'(busy_v[0]), 0);

    // random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < NL; l++) begin
        load_v[l] = ($urandom_range(0, 99) < ((l == 0) ? 2 : 6));
        data_v[l] = 9'($urandom_range(0, 511));
        rst_v[l]  = ($urandom_range(0, 999) == 0);
      end
      @(negedge clk);
    end
    load_v = '0;
    rst_v  = '0;
    for (int i = 0; i < 4000 && (busy_v !== '0 || q_head[0] != q_tail[0] || q_head[1] != q_tail[1] ||
         q_head[2] != q_tail[2]); i++) @(negedge clk);
    checkOutput("drain busy", int'(busy_v), 0);
    checkOutput("drain pending frames",
                (q_tail[0] - q_head[0]) + (q_tail[1] - q_head[1]) + (q_tail[2] - q_head[2]), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
